// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings used by the transmitter and receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE    = 16;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned GAP_TICKS     = 2 * OVERSAMPLE;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StGap   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        WordIdle = 2'd0,
        WordSend = 2'd1,
        WordGap  = 2'd2
    } word_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser paced by a 16x oversample tick; start/ready handshake.
module uart_tx_byte
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       stop_end,
    output logic       tx
);

    localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BitLast  = 3'(BITS_PER_BYTE - 1);

    uart_state_e state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        stop_end  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StStart;
                    tick_d    = '0;
                    bit_idx_d = '0;
                end
            end
            StStart: begin
                if (clken) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TickLast) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (clken) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TickLast) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == BitLast) begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StStop: begin
                if (clken) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TickLast) begin
                        stop_end  = 1'b1;
                        bit_idx_d = '0;
                        // Back-to-back chaining: a start here skips idle entirely.
                        state_d   = start ? StStart : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the state one clk later.
    always_comb begin
        case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = data[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    assign ready = (state_q == StIdle);
    assign tx    = tx_q;

endmodule

// File: rtl/uart_tx_word.sv
// Sends a DATA_WIDTH word as DATA_WIDTH/8 8N1 frames, LSB byte first.
// Define UART_TX_INTERBYTE_GAP_EN to insert 32 idle ticks between bytes.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NBYTES   = DATA_WIDTH / 8;
    localparam logic [1:0]  LastByte = 2'(NBYTES - 1);

    word_state_e           state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  done_q, done_d;
    logic                  start;
    logic                  byte_ready;
    logic                  stop_end;
    logic [31:0]           word_ext;
    logic [7:0]            byte_sel;

`ifdef UART_TX_INTERBYTE_GAP_EN
    localparam logic [4:0] GapLast = 5'(GAP_TICKS - 1);
    logic [4:0] gap_tick_q, gap_tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_tick_q <= '0;
        end else begin
            gap_tick_q <= gap_tick_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WordIdle;
            byte_idx_q <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        done_d     = 1'b0;
        start      = 1'b0;
`ifdef UART_TX_INTERBYTE_GAP_EN
        gap_tick_d = gap_tick_q;
`endif
        case (state_q)
            WordIdle: begin
                if (wr_en && byte_ready) begin
                    word_d     = data_in;
                    byte_idx_d = '0;
                    start      = 1'b1;
                    state_d    = WordSend;
                end
            end
            WordSend: begin
                if (stop_end) begin
                    if (byte_idx_q == LastByte) begin
                        state_d = WordIdle;
                        done_d  = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_TX_INTERBYTE_GAP_EN
                        state_d    = WordGap;
                        gap_tick_d = '0;
`else
                        start      = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_INTERBYTE_GAP_EN
            WordGap: begin
                if (clken) begin
                    gap_tick_d = gap_tick_q + 5'd1;
                    if (gap_tick_q == GapLast) begin
                        start   = 1'b1;
                        state_d = WordSend;
                    end
                end
            end
`endif
            default: state_d = WordIdle;
        endcase
    end

    // Widen to 32 bits so the byte select stays in range for every legal width.
    assign word_ext = 32'(word_q);
    assign byte_sel = word_ext[{byte_idx_q, 3'b000} +: 8];

    uart_tx_byte u_tx_byte (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .start    (start),
        .data     (byte_sel),
        .ready    (byte_ready),
        .stop_end (stop_end),
        .tx       (tx)
    );

    assign busy = (state_q != WordIdle);
    assign done = done_q;

endmodule
